dbnc_gea1: RTL

Generic-cell input qualifier: synchronises one asynchronous level input, requires it to hold a new value for a programmable number of consecutive clocks before passing it to the filtered output, and emits single-cycle rise/fall pulses and a saturating event count. It sits in the generic-cell library beside the combinational gates. It is the front-end cell instantiated wherever a raw pin or cross-domain level feeds gate-level logic: switch inputs, wake lines and status pins.

---
 rtl/dbnc_gea1.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dbnc_gea1.sv
// dbnc_gea1 - level-input qualifier.
// A raw asynchronous level passes through a two-flop synchroniser. A new value
// must then hold for thr consecutive clocks before the filtered output y follows
// it. Each change of y produces a one-cycle rise/fall pulse and advances a
// saturating event counter.
module dbnc_gea1 #(
  parameter int CNT_W = 8,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic [CNT_W-1:0] thr,
  input  logic             clr,
  output logic             y,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [EVT_W-1:0] evt_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_QUAL = 1'b1
  } state_t;

  logic             r_s1;
  logic             r_s2;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_y;
  logic             r_rise;
  logic             r_fall;
  logic             r_busy;
  logic [EVT_W-1:0] r_evt;

  logic [CNT_W-1:0] w_thr_eff;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_mismatch;
  logic             w_toggle;

  // Effective threshold (0 means 1), next mismatch count, and the toggle decision.
  always_comb begin
    w_thr_eff  = (thr == {CNT_W{1'b0}}) ? CNT_W'(1) : thr;
    w_cnt_inc  = {1'b0, r_cnt} + (CNT_W+1)'(1);
    w_mismatch = (r_s2 != r_y);
    w_toggle   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mismatch && (w_thr_eff == CNT_W'(1))) begin
          w_toggle = 1'b1;
        end else begin
          w_toggle = 1'b0;
        end
      end
      ST_QUAL: begin
        // The count comparison is re-evaluated every cycle against the live
        // threshold, so lowering thr mid-qualification takes effect at once.
        if (w_mismatch && (w_cnt_inc >= {1'b0, w_thr_eff})) begin
          w_toggle = 1'b1;
        end else begin
          w_toggle = 1'b0;
        end
      end
      default: w_toggle = 1'b0;
    endcase
  end

  // Synchroniser, qualification FSM, filtered level and edge pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_y     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_s1   <= a;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_toggle) begin
            r_y     <= ~r_y;
            r_rise  <= ~r_y;
            r_fall  <= r_y;
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
          end else if (w_mismatch) begin
            r_state <= ST_QUAL;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
          end
        end
        ST_QUAL: begin
          if (!w_mismatch) begin
            // Glitch ended before qualifying: drop it silently.
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
          end else if (w_toggle) begin
            r_y     <= ~r_y;
            r_rise  <= ~r_y;
            r_fall  <= r_y;
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_QUAL;
            r_cnt   <= (&r_cnt) ? r_cnt : w_cnt_inc[CNT_W-1:0];
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= {CNT_W{1'b0}};
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating toggle counter; clear has priority over a same-cycle toggle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_evt <= {EVT_W{1'b0}};
    end else if (clr) begin
      r_evt <= {EVT_W{1'b0}};
    end else if (w_toggle && !(&r_evt)) begin
      r_evt <= r_evt + EVT_W'(1);
    end else begin
      r_evt <= r_evt;
    end
  end

  assign y       = r_y;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign busy    = r_busy;
  assign evt_cnt = r_evt;

endmodule
